// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache/AXI bridge: request-type encodings, fixed AXI
// attributes, the write FSM state type and the size/length mapping helpers.
package cache_axi_pkg;

   localparam logic [2:0] REQ_BYTE = 3'd0;
   localparam logic [2:0] REQ_HALF = 3'd1;
   localparam logic [2:0] REQ_WORD = 3'd2;
   localparam logic [2:0] REQ_LINE = 3'd4;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
   localparam logic [3:0] WR_ID           = 4'hF;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_SEND,
      WR_RESP
   } wr_state_e;

   // A line request is a burst of full words; anything else is one beat of 2**type bytes.
   function automatic logic [2:0] axi_size(input logic [2:0] req_type);
      return (req_type == REQ_LINE) ? 3'd2 : req_type;
   endfunction

   function automatic logic [7:0] axi_len(input logic [2:0] req_type, input int line_words);
      return (req_type == REQ_LINE) ? 8'(line_words - 1) : 8'd0;
   endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI3 bus between the cache bridge (master) and the SoC interconnect (slave).
interface cache_axi_bridge_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/cache_axi_rd_arb.sv
// Fixed-priority read arbiter (port 0 highest) with read-after-write hazard blocking.
// CACHE_AXI_BRIDGE_RAW_CHECK_EN narrows blocking to reads that hit the line being written.
module cache_axi_rd_arb
   import cache_axi_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2,
   parameter int LINE_WORDS   = 4
) (
   input  logic [NUM_RD_PORTS-1:0]    rd_req,
   input  logic [32*NUM_RD_PORTS-1:0] rd_addr,
   input  logic                       arvalid,
   input  wr_state_e                  wr_state,
   input  logic                       wr_req,
   input  logic [31:0]                wr_addr,
   input  logic [31:0]                buf_addr,
   output logic [NUM_RD_PORTS-1:0]    rd_rdy,
   output logic [1:0]                 grant
);

   localparam int OFF = $clog2(LINE_WORDS * 4);

   logic                    found;
   logic [NUM_RD_PORTS-1:0] blocked;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         if (rd_req[i] && !found) begin
            grant = 2'(i);
            found = 1'b1;
         end
      end
   end

`ifdef CACHE_AXI_BRIDGE_RAW_CHECK_EN
   always_comb begin
      blocked = '0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         blocked[i] = ((wr_state != WR_IDLE) && (rd_addr[32*i+OFF +: 32-OFF] == buf_addr[31:OFF])) ||
                      ((wr_state == WR_IDLE) && wr_req && (rd_addr[32*i+OFF +: 32-OFF] == wr_addr[31:OFF]));
      end
   end
`else
   // The write always wins: any write in flight or being accepted stalls every read port.
   assign blocked = {NUM_RD_PORTS{(wr_state != WR_IDLE) || wr_req}};
`endif

   wire unused_addr_bits = ^{rd_addr, wr_addr, buf_addr};

   always_comb begin
      rd_rdy = '0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         rd_rdy[i] = !arvalid && found && (grant == 2'(i)) && !blocked[i];
      end
   end

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridge from N cache read ports plus one write-back port to a single AXI3 master.
// Optional feature macro: CACHE_AXI_BRIDGE_RAW_CHECK_EN (line-granular read/write hazard check).
module cache_axi_bridge
   import cache_axi_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2,
   parameter int LINE_WORDS   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   cache_axi_bridge_if.master         axi,
   input  logic [NUM_RD_PORTS-1:0]    rd_req,
   input  logic [3*NUM_RD_PORTS-1:0]  rd_type,
   input  logic [32*NUM_RD_PORTS-1:0] rd_addr,
   output logic [NUM_RD_PORTS-1:0]    rd_rdy,
   output logic [NUM_RD_PORTS-1:0]    ret_valid,
   output logic [NUM_RD_PORTS-1:0]    ret_last,
   output logic [31:0]                ret_data,
   input  logic                       wr_req,
   input  logic [2:0]                 wr_type,
   input  logic [31:0]                wr_addr,
   input  logic [3:0]                 wr_wstrb,
   input  logic [32*LINE_WORDS-1:0]   wr_data,
   output logic                       wr_rdy,
   output logic                       bus_err
);

   localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   wr_state_e                state, next_state;
   logic [1:0]               grant;
   logic                     rd_accept, wr_accept, aw_hs, w_hs;
   logic                     wline;
   logic [BEAT_W-1:0]        beat;
   logic [32*LINE_WORDS-1:0] wbuf;

   cache_axi_rd_arb #(.NUM_RD_PORTS(NUM_RD_PORTS), .LINE_WORDS(LINE_WORDS)) u_rd_arb (
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .arvalid  (axi.arvalid),
      .wr_state (state),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .buf_addr (axi.awaddr),
      .rd_rdy   (rd_rdy),
      .grant    (grant)
   );

   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = AXI_LOCK_NORMAL;
   assign axi.arcache = 4'h0;
   assign axi.arprot  = 3'h0;
   assign axi.awburst = AXI_BURST_INCR;
   assign axi.awlock  = AXI_LOCK_NORMAL;
   assign axi.awcache = 4'h0;
   assign axi.awprot  = 3'h0;
   assign axi.awid    = WR_ID;
   assign axi.wid     = WR_ID;
   assign axi.rready  = 1'b1;

   assign rd_accept = |(rd_req & rd_rdy);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         axi.arvalid <= 1'b0;
         axi.arid    <= '0;
         axi.araddr  <= '0;
         axi.arlen   <= '0;
         axi.arsize  <= '0;
      end else if (rd_accept) begin
         axi.arvalid <= 1'b1;
         axi.arid    <= {2'b00, grant};
         axi.araddr  <= rd_addr[32*grant +: 32];
         axi.arlen   <= axi_len(rd_type[3*grant +: 3], LINE_WORDS);
         axi.arsize  <= axi_size(rd_type[3*grant +: 3]);
      end else if (axi.arready) begin
         axi.arvalid <= 1'b0;
      end
   end

   assign ret_data = axi.rdata;

   always_comb begin
      ret_valid = '0;
      ret_last  = '0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         if (axi.rid == 4'(i)) begin
            ret_valid[i] = axi.rvalid;
            ret_last[i]  = axi.rvalid & axi.rlast;
         end
      end
   end

   assign wr_accept = (state == WR_IDLE) && wr_req;
   assign aw_hs     = axi.awvalid & axi.awready;
   assign w_hs      = axi.wvalid & axi.wready;
   assign axi.wlast = axi.wvalid & (!wline | (beat == BEAT_W'(LINE_WORDS - 1)));
   assign axi.wdata = wbuf[31:0];

   always_comb begin
      next_state = state;
      wr_rdy     = 1'b0;
      axi.bready = 1'b0;
      unique case (state)
         WR_IDLE: begin
            wr_rdy = 1'b1;
            if (wr_req) next_state = WR_SEND;
         end
         WR_SEND: begin
            if ((!axi.awvalid || aw_hs) && (!axi.wvalid || (w_hs && axi.wlast)))
               next_state = WR_RESP;
         end
         WR_RESP: begin
            axi.bready = 1'b1;
            if (axi.bvalid) next_state = WR_IDLE;
         end
         default: next_state = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WR_IDLE;
         axi.awvalid <= 1'b0;
         axi.wvalid  <= 1'b0;
         beat        <= '0;
      end else begin
         state <= next_state;
         if (wr_accept) begin
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            beat        <= '0;
         end else begin
            if (aw_hs) axi.awvalid <= 1'b0;
            if (w_hs) begin
               if (axi.wlast) axi.wvalid <= 1'b0;
               beat <= beat + 1'b1;
            end
         end
      end
   end

   // NOTE: the line buffer and write payload carry no reset; the valid flags alone decide whether they matter.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         wbuf       <= wr_data;
         wline      <= (wr_type == REQ_LINE);
         axi.awaddr <= wr_addr;
         axi.awlen  <= axi_len(wr_type, LINE_WORDS);
         axi.awsize <= axi_size(wr_type);
         axi.wstrb  <= (wr_type == REQ_LINE) ? 4'hF : wr_wstrb;
      end else if (w_hs) begin
         wbuf <= wbuf >> 32;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) bus_err <= 1'b0;
      else       bus_err <= (axi.rvalid & axi.rresp[1]) | (axi.bvalid & axi.bready & axi.bresp[1]);
   end

   wire unused_resp_bits = ^{axi.rresp[0], axi.bresp[0], axi.bid};

endmodule
